// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_display
// Purpose  : Time-multiplexed driver for a 4-digit common-anode seven-segment
//            display. Captures three BCD digits on a load strobe, scans the
//            anodes at a programmable rate and encodes each digit into
//            active-low segment patterns.
// Ports    : clk      - system clock, rising edge
//            reset    - synchronous, active-high reset
//            load     - capture strobe for hundreds/tens/ones
//            hundreds - BCD hundreds digit (4 bits)
//            tens     - BCD tens digit (4 bits)
//            ones     - BCD ones digit (4 bits)
//            an       - active-low anode enables, an[0] = rightmost digit
//            seg      - active-low segments {g,f,e,d,c,b,a}
//            dp       - active-low decimal point, held off
// Params   : REFRESH_DIV - clock cycles per digit slot (>= 2)
// Macro    : LEADING_ZERO_BLANK_EN - blank leading zeros in the hundreds and
//            tens positions (anode stays asserted for blanked digits)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_display #(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int                 c_DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);

  localparam logic [1:0] c_SLOT_ONES = 2'd0;
  localparam logic [1:0] c_SLOT_TENS = 2'd1;
  localparam logic [1:0] c_SLOT_HUND = 2'd2;
  localparam logic [1:0] c_SLOT_NONE = 2'd3;

  localparam logic [6:0] c_SEG_BLANK = 7'h7F;
  localparam logic [6:0] c_SEG_DASH  = 7'h3F;
  localparam logic [3:0] c_AN_OFF    = 4'b1111;

  logic [c_DIV_W-1:0] r_div_cnt;
  logic [1:0]         r_slot;
  logic [3:0]         r_h;
  logic [3:0]         r_t;
  logic [3:0]         r_o;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic               w_slot_end;
  logic [3:0]         w_digit;
  logic               w_blank;
  logic [3:0]         w_an;
  logic [6:0]         w_seg;

  function automatic logic [6:0] f_encode(input logic [3:0] i_d);
    logic [6:0] v;
    case (i_d)
      4'd0:    v = 7'h40;
      4'd1:    v = 7'h79;
      4'd2:    v = 7'h24;
      4'd3:    v = 7'h30;
      4'd4:    v = 7'h19;
      4'd5:    v = 7'h12;
      4'd6:    v = 7'h02;
      4'd7:    v = 7'h78;
      4'd8:    v = 7'h00;
      4'd9:    v = 7'h10;
      default: v = c_SEG_DASH;  // nibbles 10-15 are not BCD
    endcase
    return v;
  endfunction

  assign w_slot_end = (r_div_cnt == c_DIV_LAST);

  // Next display values are derived from the slot and captures as they stand
  // before the edge, so the outputs trail r_slot by exactly one cycle.
  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b0;
    w_an    = c_AN_OFF;
    case (r_slot)
      c_SLOT_ONES: begin
        w_digit = r_o;
        w_an    = 4'b1110;
      end
      c_SLOT_TENS: begin
        w_digit = r_t;
        w_an    = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (r_h == 4'd0) && (r_t == 4'd0);
`endif
      end
      c_SLOT_HUND: begin
        w_digit = r_h;
        w_an    = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (r_h == 4'd0);
`endif
      end
      default: begin
        // Fourth position is not populated: anode off, segments dark.
        w_blank = 1'b1;
        w_an    = c_AN_OFF;
      end
    endcase
    w_seg = w_blank ? c_SEG_BLANK : f_encode(w_digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_slot    <= c_SLOT_ONES;
      r_h       <= 4'd0;
      r_t       <= 4'd0;
      r_o       <= 4'd0;
      r_an      <= c_AN_OFF;
      r_seg     <= c_SEG_BLANK;
      r_dp      <= 1'b1;
    end else begin
      if (load) begin
        r_h <= hundreds;
        r_t <= tens;
        r_o <= ones;
      end
      if (w_slot_end) begin
        r_div_cnt <= '0;
        r_slot    <= r_slot + 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + c_DIV_W'(1);
      end
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= 1'b1;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
`default_nettype wire
